hazard_stall_ctrl: RTL and testbench

- Generates the pipeline-wide `stall` that the fetch-stage NOP-select logic and all pipeline registers consume.
- Stall causes: load-use data hazards, i-cache response waits and d-cache response waits.
- Sits between the decode/execute pipeline registers and the cache request/response handshakes.
- Holds `stall` for exactly as long as each hazard requires, with a fixed priority between causes.

---
 rtl/hazard_stall_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline stall generator for load-use, i-cache and d-cache waits
// Optional per-cause stall-cycle counters when STALL_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int WAIT_TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] id_inst,
  input  logic [31:0] ex_inst,
  input  logic        icache_req_valid,
  input  logic        icache_resp_valid,
  input  logic        dcache_req_valid,
  input  logic        dcache_resp_valid,
  output logic        stall,
  output logic [1:0]  stall_cause,
  output logic        timeout_err
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_cycles,
  output logic [31:0] perf_ic_cycles,
  output logic [31:0] perf_dc_cycles
`endif
);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_LU   = 2'd1;
  localparam logic [1:0] CAUSE_IC   = 2'd2;
  localparam logic [1:0] CAUSE_DC   = 2'd3;

  localparam logic [2:0] LU_INIT     = 3'(LOAD_USE_BUBBLES - 1);
  localparam logic [7:0] TIMEOUT_VAL = 8'(WAIT_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_USE,
    S_IWAIT,
    S_DWAIT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_bubble_cnt;
  logic [2:0]  w_bubble_nxt;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_plus;
  logic        r_timeout_err;
  logic        w_wait_clr;
  logic        w_wait_inc;
  logic        w_stall;
  logic [1:0]  w_cause;

  logic [6:0]  w_ex_opc;
  logic [4:0]  w_ex_rd;
  logic [6:0]  w_id_opc;
  logic [4:0]  w_id_rs1;
  logic [4:0]  w_id_rs2;
  logic        w_id_uses_rs1;
  logic        w_id_uses_rs2;
  logic        w_load_use;
  logic        w_imiss;
  logic        w_dmiss;
  logic        w_unused;

  assign w_ex_opc = ex_inst[6:0];
  assign w_ex_rd  = ex_inst[11:7];
  assign w_id_opc = id_inst[6:0];
  assign w_id_rs1 = id_inst[19:15];
  assign w_id_rs2 = id_inst[24:20];
  assign w_unused = ^{id_inst[31:25], id_inst[14:7], ex_inst[31:12]};

  always_comb begin
    w_id_uses_rs1 = 1'b0;
    case (w_id_opc)
      OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_ARI_ITYPE, OPC_ARI_RTYPE, OPC_JALR: w_id_uses_rs1 = 1'b1;
      default:                                w_id_uses_rs1 = 1'b0;
    endcase
  end

  assign w_id_uses_rs2 = (w_id_opc == OPC_BRANCH) || (w_id_opc == OPC_STORE) ||
                         (w_id_opc == OPC_ARI_RTYPE);

  // A load into x0 never produces a value, so it cannot create a hazard.
  assign w_load_use = (w_ex_opc == OPC_LOAD) && (w_ex_rd != 5'd0) &&
                      ((w_id_uses_rs1 && (w_ex_rd == w_id_rs1)) ||
                       (w_id_uses_rs2 && (w_ex_rd == w_id_rs2)));

  assign w_imiss = icache_req_valid & ~icache_resp_valid;
  assign w_dmiss = dcache_req_valid & ~dcache_resp_valid;

  always_comb begin
    w_state_nxt  = r_state;
    w_bubble_nxt = r_bubble_cnt;
    w_stall      = 1'b0;
    w_cause      = CAUSE_NONE;
    w_wait_clr   = 1'b0;
    w_wait_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dmiss) begin
          w_state_nxt = S_DWAIT;
          w_stall     = 1'b1;
          w_cause     = CAUSE_DC;
          w_wait_clr  = 1'b1;
        end else if (w_imiss) begin
          w_state_nxt = S_IWAIT;
          w_stall     = 1'b1;
          w_cause     = CAUSE_IC;
          w_wait_clr  = 1'b1;
        end else if (w_load_use) begin
          w_state_nxt  = S_LOAD_USE;
          w_stall      = 1'b1;
          w_cause      = CAUSE_LU;
          w_bubble_nxt = LU_INIT;
        end
      end
      S_LOAD_USE: begin
        if (r_bubble_cnt == 3'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_stall      = 1'b1;
          w_cause      = CAUSE_LU;
          w_bubble_nxt = r_bubble_cnt - 3'd1;
        end
      end
      S_IWAIT: begin
        w_wait_inc = 1'b1;
        if (icache_resp_valid) begin
          // A d-cache miss raised in the fetch-return cycle is taken directly.
          if (w_dmiss) begin
            w_state_nxt = S_DWAIT;
            w_wait_clr  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_stall = 1'b1;
          w_cause = CAUSE_IC;
        end
      end
      S_DWAIT: begin
        w_wait_inc = 1'b1;
        if (dcache_resp_valid) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_stall = 1'b1;
          w_cause = CAUSE_DC;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_wait_plus = (r_wait_cnt == 8'hFF) ? 8'hFF : (r_wait_cnt + 8'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_bubble_cnt  <= 3'd0;
      r_wait_cnt    <= 8'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bubble_cnt <= w_bubble_nxt;
      if (w_wait_clr) begin
        r_wait_cnt <= 8'd0;
      end else if (w_wait_inc) begin
        r_wait_cnt <= w_wait_plus;
      end
      if (w_wait_inc && (w_wait_plus >= TIMEOUT_VAL)) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // Reset must silence the stall immediately, even with a miss on the inputs.
  assign stall       = reset_n & w_stall;
  assign stall_cause = reset_n ? w_cause : CAUSE_NONE;
  assign timeout_err = r_timeout_err;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_perf_lu;
  logic [31:0] r_perf_ic;
  logic [31:0] r_perf_dc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_lu <= 32'd0;
      r_perf_ic <= 32'd0;
      r_perf_dc <= 32'd0;
    end else if (stall) begin
      if (stall_cause == CAUSE_LU) r_perf_lu <= r_perf_lu + 32'd1;
      if (stall_cause == CAUSE_IC) r_perf_ic <= r_perf_ic + 32'd1;
      if (stall_cause == CAUSE_DC) r_perf_dc <= r_perf_dc + 32'd1;
    end
  end

  assign perf_lu_cycles = r_perf_lu;
  assign perf_ic_cycles = r_perf_ic;
  assign perf_dc_cycles = r_perf_dc;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl (two parameter sets)
module tb_hazard_stall_ctrl;

  localparam int B0 = 1;
  localparam int T0 = 255;
  localparam int B1 = 3;
  localparam int T1 = 10;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] id_inst, ex_inst;
  logic        ireq, iresp, dreq, dresp;
  logic        stall_o [2];
  logic [1:0]  cause_o [2];
  logic        terr_o  [2];
`ifdef STALL_PERF_CNT_EN
  logic [31:0] plu_o [2];
  logic [31:0] pic_o [2];
  logic [31:0] pdc_o [2];
`endif

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.LOAD_USE_BUBBLES(B0), .WAIT_TIMEOUT(T0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .id_inst(id_inst), .ex_inst(ex_inst),
    .icache_req_valid(ireq), .icache_resp_valid(iresp),
    .dcache_req_valid(dreq), .dcache_resp_valid(dresp),
    .stall(stall_o[0]), .stall_cause(cause_o[0]), .timeout_err(terr_o[0])
`ifdef STALL_PERF_CNT_EN
    , .perf_lu_cycles(plu_o[0]), .perf_ic_cycles(pic_o[0]), .perf_dc_cycles(pdc_o[0])
`endif
  );

  hazard_stall_ctrl #(.LOAD_USE_BUBBLES(B1), .WAIT_TIMEOUT(T1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .id_inst(id_inst), .ex_inst(ex_inst),
    .icache_req_valid(ireq), .icache_resp_valid(iresp),
    .dcache_req_valid(dreq), .dcache_resp_valid(dresp),
    .stall(stall_o[1]), .stall_cause(cause_o[1]), .timeout_err(terr_o[1])
`ifdef STALL_PERF_CNT_EN
    , .perf_lu_cycles(plu_o[1]), .perf_ic_cycles(pic_o[1]), .perf_dc_cycles(pdc_o[1])
`endif
  );

  typedef struct packed {
    logic [1:0]      s;
    logic [1:0][1:0] c;
    logic [1:0]      t;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          win_stall [2];

  int          bub [2] = '{B0, B1};
  int          tmo [2] = '{T0, T1};
  int          lu_rem [2];
  bit          iw [2];
  bit          dw [2];
  int          wc [2];
  bit          terr_m [2];
  int unsigned perf_m [2][4];

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic bit is_load_use(input logic [31:0] ex, input logic [31:0] id);
    int unsigned e = ex;
    int unsigned i = id;
    int unsigned eo = e % 128;
    int unsigned rd = (e / 128) % 32;
    int unsigned io = i % 128;
    int unsigned r1 = (i / 32768) % 32;
    int unsigned r2 = (i / 1048576) % 32;
    bit u1 = io inside {3, 35, 99, 19, 51, 103};
    bit u2 = io inside {99, 35, 51};
    return (eo == 3) && (rd != 0) && ((u1 && rd == r1) || (u2 && rd == r2));
  endfunction

  task automatic reset_model(input int d);
    lu_rem[d] = 0; iw[d] = 0; dw[d] = 0; wc[d] = 0; terr_m[d] = 0;
    for (int k = 0; k < 4; k++) perf_m[d][k] = 0;
  endtask

  task automatic wait_tick(input int d);
    wc[d] = (wc[d] < 255) ? wc[d] + 1 : 255;
    if (wc[d] >= tmo[d]) terr_m[d] = 1;
  endtask

  // Outputs for the current cycle, then the model advances past the clock edge.
  task automatic model_step(input int d, output bit s, output logic [1:0] c);
    s = 0; c = 0;
    if (!reset_n) return;
    if (dw[d]) begin
      wait_tick(d);
      if (dresp) dw[d] = 0;
      else begin s = 1; c = 3; end
    end else if (iw[d]) begin
      wait_tick(d);
      if (iresp) begin
        iw[d] = 0;
        if (dreq && !dresp) begin dw[d] = 1; wc[d] = 0; end
      end else begin s = 1; c = 2; end
    end else if (lu_rem[d] > 0) begin
      s = (lu_rem[d] > 1);
      c = s ? 2'd1 : 2'd0;
      lu_rem[d]--;
    end else if (dreq && !dresp) begin
      s = 1; c = 3; dw[d] = 1; wc[d] = 0;
    end else if (ireq && !iresp) begin
      s = 1; c = 2; iw[d] = 1; wc[d] = 0;
    end else if (is_load_use(ex_inst, id_inst)) begin
      s = 1; c = 1; lu_rem[d] = bub[d];
    end
    if (s) perf_m[d][c]++;
  endtask

  task automatic cycle(input bit rn, input logic [31:0] idi, input logic [31:0] exi,
                       input bit ir, input bit irp, input bit dr, input bit drp);
    exp_t e;
    bit s;
    logic [1:0] c;
    @(posedge clk);
    #1;
    reset_n = rn; id_inst = idi; ex_inst = exi;
    ireq = ir; iresp = irp; dreq = dr; dresp = drp;
    for (int d = 0; d < 2; d++) begin
      if (!rn) reset_model(d);
      e.t[d] = terr_m[d];
      model_step(d, s, c);
      e.s[d] = s;
      e.c[d] = c;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1, NOP, NOP, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int d = 0; d < 2; d++) begin
        chk("stall", d, stall_o[d], e.s[d]);
        chk("stall_cause", d, cause_o[d], e.c[d]);
        chk("timeout_err", d, terr_o[d], e.t[d]);
        if (stall_o[d]) win_stall[d]++;
      end
    end
  end

  function automatic logic [31:0] rand_inst();
    int unsigned opcs [8] = '{3, 35, 99, 19, 51, 103, 55, 111};
    logic [31:0] v;
    v = opcs[$urandom_range(0, 7)];
    v[11:7]  = 5'($urandom_range(0, 3));
    v[14:12] = 3'($urandom_range(0, 7));
    v[19:15] = 5'($urandom_range(0, 3));
    v[24:20] = 5'($urandom_range(0, 3));
    v[31:25] = 7'($urandom_range(0, 127));
    return v;
  endfunction

  localparam logic [31:0] LW_X5   = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
  localparam logic [31:0] ADD_X6  = {7'd0, 5'd2, 5'd5, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] LW_X0   = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
  localparam logic [31:0] ADD_X0  = {7'd0, 5'd2, 5'd0, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] LW_X7   = {12'd0, 5'd1, 3'b010, 5'd7, 7'b0000011};
  localparam logic [31:0] SW_X7   = {7'd0, 5'd7, 5'd2, 3'b010, 5'd4, 7'b0100011};

  initial begin
    reset_n = 0; id_inst = NOP; ex_inst = NOP;
    ireq = 0; iresp = 0; dreq = 0; dresp = 0;
    reset_model(0); reset_model(1);

    cycle(0, NOP, NOP, 1, 0, 1, 0);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_stall", d, stall_o[d], 0);
      chk("reset_terr", d, terr_o[d], 0);
    end
    cycle(0, NOP, NOP, 0, 0, 0, 0);
    idle(3);

    win_stall = '{0, 0};
    cycle(1, ADD_X6, LW_X5, 0, 0, 0, 0);
    idle(6); settle();
    chk("lu_len", 0, win_stall[0], 1);
    chk("lu_len", 1, win_stall[1], 3);

    win_stall = '{0, 0};
    cycle(1, ADD_X0, LW_X0, 0, 0, 0, 0);
    idle(4); settle();
    chk("x0_len", 0, win_stall[0], 0);
    chk("x0_len", 1, win_stall[1], 0);

    win_stall = '{0, 0};
    for (int k = 0; k < 4; k++) cycle(1, NOP, NOP, 1, 0, 0, 0);
    cycle(1, NOP, NOP, 1, 1, 0, 0);
    idle(3); settle();
    chk("ic_len", 0, win_stall[0], 4);
    chk("ic_len", 1, win_stall[1], 4);
`ifdef STALL_PERF_CNT_EN
    chk("perf_lu", 0, plu_o[0], 1);
    chk("perf_ic", 0, pic_o[0], 4);
    chk("perf_dc", 0, pdc_o[0], 0);
`endif

    win_stall = '{0, 0};
    cycle(1, SW_X7, LW_X7, 0, 0, 0, 0);
    idle(6); settle();
    chk("mb_len", 0, win_stall[0], 1);
    chk("mb_len", 1, win_stall[1], 3);

    win_stall = '{0, 0};
    cycle(1, NOP, NOP, 1, 0, 1, 0);
    cycle(1, NOP, NOP, 1, 0, 1, 0);
    cycle(1, NOP, NOP, 1, 0, 1, 1);
    cycle(1, NOP, NOP, 1, 0, 0, 0);
    cycle(1, NOP, NOP, 1, 0, 0, 0);
    cycle(1, NOP, NOP, 1, 1, 0, 0);
    idle(3); settle();
    chk("prio_len", 0, win_stall[0], 4);
    chk("prio_len", 1, win_stall[1], 4);

    cycle(1, NOP, NOP, 0, 0, 1, 0);
    idle(13);
    #1;
    chk("to_terr", 1, terr_o[1], 1);
    chk("to_terr", 0, terr_o[0], 0);
    chk("to_stall", 1, stall_o[1], 1);
    cycle(0, NOP, NOP, 0, 0, 1, 0);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("midrst_stall", d, stall_o[d], 0);
      chk("midrst_terr", d, terr_o[d], 0);
    end
    idle(3);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ex;
      logic [31:0] id;
      ex = rand_inst();
      id = rand_inst();
      cycle(($urandom_range(0, 399) != 0), id, ex,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
    end
    for (int k = 0; k < 4; k++) cycle(1, NOP, NOP, 0, 1, 0, 1);
    idle(10);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
`ifdef STALL_PERF_CNT_EN
    for (int d = 0; d < 2; d++) begin
      chk("perf_lu_end", d, plu_o[d], perf_m[d][1]);
      chk("perf_ic_end", d, pic_o[d], perf_m[d][2]);
      chk("perf_dc_end", d, pdc_o[d], perf_m[d][3]);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
